// File: rtl/dma_pkg.sv
// Shared types and default widths for the DMA copy engine.
package dma_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/dma_xfer_engine_if.sv
// Command, read-port and write-port bundle of the DMA copy engine.
interface dma_xfer_engine_if #(
  parameter int ADDR_W = dma_pkg::ADDR_W,
  parameter int DATA_W = dma_pkg::DATA_W,
  parameter int LEN_W  = dma_pkg::LEN_W
);

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [ADDR_W-1:0] cmd_src_i;
  logic [ADDR_W-1:0] cmd_dst_i;
  logic [LEN_W-1:0]  cmd_len_i;

  logic              rd_req_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              rd_gnt_i;
  logic              rd_data_valid_i;
  logic [DATA_W-1:0] rd_data_i;

  logic              wr_req_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              wr_gnt_i;

  modport master (
    input  cmd_valid_i, cmd_src_i, cmd_dst_i, cmd_len_i,
    output cmd_ready_o,
    output rd_req_o, rd_addr_o,
    input  rd_gnt_i, rd_data_valid_i, rd_data_i,
    output wr_req_o, wr_addr_o, wr_data_o,
    input  wr_gnt_i
  );

  modport slave (
    output cmd_valid_i, cmd_src_i, cmd_dst_i, cmd_len_i,
    input  cmd_ready_o,
    input  rd_req_o, rd_addr_o,
    output rd_gnt_i, rd_data_valid_i, rd_data_i,
    input  wr_req_o, wr_addr_o, wr_data_o,
    output wr_gnt_i
  );

endinterface

// File: rtl/dma_sync_fifo.sv
// Synchronous FIFO with registered storage, full/empty flags and occupancy.
module dma_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/dma_xfer_engine.sv
// Single-channel memory-to-memory copy engine: credit-limited reads
// feed a small FIFO that drains as writes.
module dma_xfer_engine #(
  parameter int ADDR_W     = dma_pkg::ADDR_W,
  parameter int DATA_W     = dma_pkg::DATA_W,
  parameter int LEN_W      = dma_pkg::LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  dma_xfer_engine_if.master  bus,
  output logic               busy_o,
  output logic               done_o
);

  import dma_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(DATA_W / 8);
  localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);
  localparam logic [CW-1:0]     CR_ONE  = CW'(1);
  localparam logic [CW:0]       CR_MAX  = (CW+1)'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     infl_q, infl_d;

  logic              cmd_ready, rd_req, wr_req;
  logic              accept, rd_fire, push, pop, last_wr;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic [CW:0]       credit;

  dma_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .data_i    (bus.rd_data_i),
    .pop_i     (pop),
    .data_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  // Reads outstanding plus buffered words never exceed the FIFO depth.
  assign credit  = {1'b0, infl_q} + {1'b0, fifo_cnt};
  assign accept  = cmd_ready && bus.cmd_valid_i;
  assign rd_fire = rd_req && bus.rd_gnt_i;
  assign push    = bus.rd_data_valid_i && (infl_q != '0) && !fifo_full;
  assign pop     = wr_req && bus.wr_gnt_i;
  assign last_wr = pop && (wr_cnt_q == len_q - LEN_ONE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)
              state_d = (bus.cmd_len_i == '0) ? DONE : RUN;
      RUN:  if (last_wr) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      IDLE: cmd_ready = reset_n_i;
      RUN: begin
        busy_o = 1'b1;
        rd_req = (rd_cnt_q != len_q) && (credit < CR_MAX);
        wr_req = !fifo_empty;
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    len_d     = len_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    infl_d    = infl_q;
    if (accept) begin
      rd_addr_d = bus.cmd_src_i;
      wr_addr_d = bus.cmd_dst_i;
      len_d     = bus.cmd_len_i;
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
    end
    if (rd_fire) begin
      rd_addr_d = rd_addr_q + STRIDE;
      rd_cnt_d  = rd_cnt_q + LEN_ONE;
    end
    if (pop) begin
      wr_addr_d = wr_addr_q + STRIDE;
      wr_cnt_d  = wr_cnt_q + LEN_ONE;
    end
    unique case ({rd_fire, push})
      2'b10:   infl_d = infl_q + CR_ONE;
      2'b01:   infl_d = infl_q - CR_ONE;
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      infl_q    <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      infl_q    <= infl_d;
    end
  end

  assign bus.cmd_ready_o = cmd_ready;
  assign bus.rd_req_o    = rd_req;
  assign bus.rd_addr_o   = rd_addr_q;
  assign bus.wr_req_o    = wr_req;
  assign bus.wr_addr_o   = wr_addr_q;
  // Storage is unreset, so the head is masked until it holds real data.
  assign bus.wr_data_o   = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Directed bench for dma_xfer_engine: zero-wait memory model,
// per-scenario tasks with hand-derived expectations.
module tb_dma_xfer_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done;
  logic wr_en = 1'b1;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  logic [31:0] pend[$];
  logic [31:0] rd_log[$];
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];
  int rc_log[$];
  int wc_log[$];
  int done_log[$];
  int acc_log[$];
  int rdreq_n, wrreq_n;

  dma_xfer_engine_if #() bus ();

  dma_xfer_engine dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus.master),
    .busy_o    (busy),
    .done_o    (done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: zero-wait grants, read data one cycle after grant.
  initial begin
    bus.rd_gnt_i = 1'b0;
    bus.rd_data_valid_i = 1'b0;
    bus.rd_data_i = '0;
    bus.wr_gnt_i = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pend.delete();
        bus.rd_gnt_i = 1'b0;
        bus.rd_data_valid_i = 1'b0;
        bus.wr_gnt_i = 1'b0;
      end else begin
        bus.rd_data_valid_i = 1'b0;
        if (pend.size() > 0) begin
          bus.rd_data_valid_i = 1'b1;
          bus.rd_data_i = mdata(pend.pop_front());
        end
        bus.rd_gnt_i = bus.rd_req_o;
        if (bus.rd_gnt_i) begin
          pend.push_back(bus.rd_addr_o);
          rd_log.push_back(bus.rd_addr_o);
          rc_log.push_back(cyc);
        end
        bus.wr_gnt_i = bus.wr_req_o & wr_en;
        if (bus.wr_gnt_i) begin
          wa_log.push_back(bus.wr_addr_o);
          wd_log.push_back(bus.wr_data_o);
          wc_log.push_back(cyc);
        end
        if (done) done_log.push_back(cyc);
        if (bus.cmd_valid_i && bus.cmd_ready_o) acc_log.push_back(cyc);
        rdreq_n += int'(bus.rd_req_o);
        wrreq_n += int'(bus.wr_req_o);
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    rc_log.delete(); wc_log.delete();
    done_log.delete(); acc_log.delete();
    rdreq_n = 0;
    wrreq_n = 0;
  endtask

  task automatic start_cmd(input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] len, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_src_i = src;
    bus.cmd_dst_i = dst;
    bus.cmd_len_i = len;
    for (int i = 0; i < 50; i++) begin
      #2;
      if (bus.cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int n0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #3;
      if (done_log.size() > n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({bus.cmd_ready_o, bus.rd_req_o, bus.wr_req_o, busy, done} !== 5'b0) begin
      failed++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.cmd_ready_o, bus.rd_req_o, bus.wr_req_o, busy, done});
    end
    tests++;
    if ({bus.rd_addr_o, bus.wr_addr_o, bus.wr_data_o} !== 96'h0) begin
      failed++;
      $display("FAIL reset_bus: got %h/%h/%h expected 0",
               bus.rd_addr_o, bus.wr_addr_o, bus.wr_data_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.cmd_ready_o !== 1'b1) begin
      failed++;
      $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready_o);
    end
  endtask

  task automatic test_basic();
    bit ok_s, ok_d;
    clear_logs();
    start_cmd(32'h100, 32'h200, 16'd4, ok_s);
    wait_done(0, ok_d);
    tests++;
    if ({ok_s, ok_d} !== 2'b11) begin
      failed++;
      $display("FAIL basic_handshake: got %b expected 11", {ok_s, ok_d});
    end
    tests++;
    if (rd_log.size() != 4 || wa_log.size() != 4) begin
      failed++;
      $display("FAIL basic_counts: got rd %0d wr %0d expected 4 4",
               rd_log.size(), wa_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (rd_log[i] !== 32'h100 + 32'(4 * i) ||
            wa_log[i] !== 32'h200 + 32'(4 * i) ||
            wd_log[i] !== mdata(32'h100 + 32'(4 * i))) begin
          failed++;
          $display("FAIL basic_word%0d: got rd %h wa %h wd %h expected %h %h %h",
                   i, rd_log[i], wa_log[i], wd_log[i], 32'h100 + 32'(4 * i),
                   32'h200 + 32'(4 * i), mdata(32'h100 + 32'(4 * i)));
        end
      end
      tests++;
      if (rc_log[0] != acc_log[0] + 1 || wc_log[0] != rc_log[0] + 2) begin
        failed++;
        $display("FAIL basic_latency: got acc %0d rd %0d wr %0d expected rd=acc+1 wr=rd+2",
                 acc_log[0], rc_log[0], wc_log[0]);
      end
      tests++;
      if (wc_log[3] != wc_log[0] + 3) begin
        failed++;
        $display("FAIL basic_throughput: got span %0d expected 3",
                 wc_log[3] - wc_log[0]);
      end
      tests++;
      if (done_log[0] != wc_log[3] + 1) begin
        failed++;
        $display("FAIL basic_done_time: got %0d expected %0d",
                 done_log[0], wc_log[3] + 1);
      end
    end
    repeat (3) @(negedge clk);
    #3;
    tests++;
    if (done_log.size() != 1 || busy !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      failed++;
      $display("FAIL basic_after: got done %0d busy %b ready %b expected 1 0 1",
               done_log.size(), busy, bus.cmd_ready_o);
    end
  endtask

  task automatic test_len0();
    bit ok_s, ok_d;
    clear_logs();
    start_cmd(32'h500, 32'h600, 16'd0, ok_s);
    wait_done(0, ok_d);
    repeat (3) @(negedge clk);
    #3;
    tests++;
    if (!ok_s || !ok_d || done_log[0] != acc_log[0] + 1) begin
      failed++;
      $display("FAIL len0_done: got ok %b%b done %0d acc %0d expected done=acc+1",
               ok_s, ok_d, done_log[0], acc_log[0]);
    end
    tests++;
    if (rdreq_n != 0 || wrreq_n != 0) begin
      failed++;
      $display("FAIL len0_noreq: got rd %0d wr %0d expected 0 0", rdreq_n, wrreq_n);
    end
  endtask

  task automatic test_stall();
    bit ok_s, ok_d;
    clear_logs();
    wr_en = 1'b0;
    start_cmd(32'h1000, 32'h2000, 16'd10, ok_s);
    repeat (20) @(negedge clk);
    #3;
    tests++;
    if (rd_log.size() != 4 || wa_log.size() != 0) begin
      failed++;
      $display("FAIL stall_credit: got rd %0d wr %0d expected 4 0",
               rd_log.size(), wa_log.size());
    end
    tests++;
    if (bus.wr_req_o !== 1'b1 || bus.wr_addr_o !== 32'h2000 ||
        bus.wr_data_o !== mdata(32'h1000)) begin
      failed++;
      $display("FAIL stall_hold: got %b %h %h expected 1 00002000 %h",
               bus.wr_req_o, bus.wr_addr_o, bus.wr_data_o, mdata(32'h1000));
    end
    wr_en = 1'b1;
    wait_done(0, ok_d);
    tests++;
    if (!ok_s || !ok_d || wa_log.size() != 10) begin
      failed++;
      $display("FAIL stall_finish: got ok %b%b writes %0d expected 11 10",
               ok_s, ok_d, wa_log.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests++;
        if (wa_log[i] !== 32'h2000 + 32'(4 * i) ||
            wd_log[i] !== mdata(32'h1000 + 32'(4 * i))) begin
          failed++;
          $display("FAIL stall_word%0d: got %h %h expected %h %h", i, wa_log[i],
                   wd_log[i], 32'h2000 + 32'(4 * i), mdata(32'h1000 + 32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok_s, ok_d;
    clear_logs();
    start_cmd(32'hFFFF_FFFC, 32'h10, 16'd2, ok_s);
    wait_done(0, ok_d);
    tests++;
    if (!ok_s || !ok_d || rd_log.size() != 2 || wd_log.size() != 2) begin
      failed++;
      $display("FAIL wrap_counts: got ok %b%b rd %0d wr %0d expected 11 2 2",
               ok_s, ok_d, rd_log.size(), wd_log.size());
    end else begin
      tests++;
      if (rd_log[0] !== 32'hFFFF_FFFC || rd_log[1] !== 32'h0 ||
          wd_log[1] !== mdata(32'h0) || wa_log[1] !== 32'h14) begin
        failed++;
        $display("FAIL wrap_addr: got %h %h wd %h wa %h expected fffffffc 00000000 %h 00000014",
                 rd_log[0], rd_log[1], wd_log[1], wa_log[1], mdata(32'h0));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok_s, ok_d;
    clear_logs();
    start_cmd(32'h300, 32'h700, 16'd8, ok_s);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #3;
      if (wa_log.size() >= 3) break;
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.cmd_ready_o, bus.rd_req_o, bus.wr_req_o, busy, done} !== 5'b0 ||
        {bus.rd_addr_o, bus.wr_addr_o, bus.wr_data_o} !== 96'h0) begin
      failed++;
      $display("FAIL midreset_outputs: got %b %h %h %h expected all 0",
               {bus.cmd_ready_o, bus.rd_req_o, bus.wr_req_o, busy, done},
               bus.rd_addr_o, bus.wr_addr_o, bus.wr_data_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.cmd_ready_o !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL midreset_idle: got ready %b busy %b expected 1 0",
               bus.cmd_ready_o, busy);
    end
    clear_logs();
    start_cmd(32'h800, 32'h900, 16'd2, ok_s);
    wait_done(0, ok_d);
    tests++;
    if (!ok_s || !ok_d || wd_log.size() != 2 ||
        wd_log[0] !== mdata(32'h800) || wd_log[1] !== mdata(32'h804) ||
        wa_log[1] !== 32'h904) begin
      failed++;
      $display("FAIL midreset_rerun: got ok %b%b n %0d wd0 %h wd1 %h wa1 %h expected %h %h 00000904",
               ok_s, ok_d, wd_log.size(), wd_log[0], wd_log[1], wa_log[1],
               mdata(32'h800), mdata(32'h804));
    end
  endtask

  task automatic test_back_to_back();
    bit ok_d;
    logic [31:0] exp_a [5];
    logic [31:0] exp_d [5];
    exp_a = '{32'hB00, 32'hB04, 32'hD00, 32'hD04, 32'hD08};
    exp_d = '{mdata(32'hA00), mdata(32'hA04), mdata(32'hC00),
              mdata(32'hC04), mdata(32'hC08)};
    clear_logs();
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_src_i = 32'hA00;
    bus.cmd_dst_i = 32'hB00;
    bus.cmd_len_i = 16'd2;
    for (int i = 0; i < 50; i++) begin
      #2;
      if (bus.cmd_ready_o) break;
      @(negedge clk);
    end
    @(negedge clk);
    bus.cmd_src_i = 32'hC00;
    bus.cmd_dst_i = 32'hD00;
    bus.cmd_len_i = 16'd3;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (bus.cmd_ready_o) break;
      @(negedge clk);
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    wait_done(1, ok_d);
    tests++;
    if (!ok_d || acc_log.size() != 2 || done_log.size() != 2 ||
        acc_log[1] != done_log[0] + 1) begin
      failed++;
      $display("FAIL b2b_accept: got ok %b acc %0d done %0d, acc1 %0d done0 %0d expected acc1=done0+1",
               ok_d, acc_log.size(), done_log.size(), acc_log[1], done_log[0]);
    end
    tests++;
    if (wa_log.size() != 5) begin
      failed++;
      $display("FAIL b2b_count: got %0d expected 5", wa_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (wa_log[i] !== exp_a[i] || wd_log[i] !== exp_d[i]) begin
          failed++;
          $display("FAIL b2b_word%0d: got %h %h expected %h %h",
                   i, wa_log[i], wd_log[i], exp_a[i], exp_d[i]);
        end
      end
    end
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_src_i = '0;
    bus.cmd_dst_i = '0;
    bus.cmd_len_i = '0;
    rdreq_n = 0;
    wrreq_n = 0;
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
